rf_write_arbiter: RTL

Shares the single register-file write port (regWrite/rd/write_Data) between the in-order pipeline writeback stage and a long-latency multicycle unit (divider/multiplier). Multicycle results are buffered in a small FIFO and drained into idle write slots. A destination scoreboard produces the decode-stage stall signal for RAW/WAW hazards against in-flight multicycle ops. An age counter bounds queue starvation by briefly holding the pipeline.

---
 rtl/rf_write_arbiter_pkg.sv | 15 +
 rtl/rf_wr_fifo.sv | 69 ++++++
 rtl/rf_write_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter.
package rf_write_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] RD_ZERO = '0;

    // x0 is hardwired to zero, so requests that target it carry no work.
    function automatic logic rd_is_live(input logic [REG_ADDR_W-1:0] rd);
        return rd != RD_ZERO;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Small FIFO buffering multicycle results ({rd, data}) until the write
// port is free. The head is visible combinationally so it can be written
// in the same cycle it is popped.
module rf_wr_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int W      = XLEN,
    parameter int QDEPTH = 2,
    localparam int PW    = $clog2(QDEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [W-1:0]          head_data,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    logic [REG_ADDR_W-1:0] rd_mem_q   [QDEPTH];
    logic [W-1:0]          data_mem_q [QDEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push,  do_pop;

    assign full      = (count_q == CW'(QDEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_rd   = rd_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally (QDEPTH is a power of 2).
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count says empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem_q[wr_ptr_q]   <= push_rd;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and a
// buffered multicycle unit, tracks in-flight multicycle destinations for
// decode stalls, and forces a one-cycle pipeline hold when a queued
// result has waited too long.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int XLEN         = rf_write_arbiter_pkg::XLEN,
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  ml_issue,
    input  logic [REG_ADDR_W-1:0] ml_issue_rd,
    input  logic                  ml_valid,
    input  logic [REG_ADDR_W-1:0] ml_rd,
    input  logic [XLEN-1:0]       ml_data,
    output logic                  ml_ready,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    output logic                  dec_stall,
    output logic                  wb_hold,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [$clog2(QDEPTH):0] q_count
);

    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX  = AW'(STARVE_LIMIT);
    localparam logic [AW-1:0] AGE_TRIG = AW'(STARVE_LIMIT - 1);

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [AW-1:0]         age_q, age_d;
    logic                  wb_hold_q, wb_hold_d;

    logic                  wb_eff, sel_wb, pop, push;
    logic                  q_full, q_empty;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;

    // Results to x0 are handshaken but never stored.
    assign push     = ml_valid && ml_ready && rd_is_live(ml_rd);
    assign ml_ready = !q_full;
    assign wb_hold  = wb_hold_q;

    rf_wr_fifo #(
        .W      (XLEN),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_rd   (ml_rd),
        .push_data (ml_data),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Write-port select: WB has priority unless the hold hands the port to the queue.
    always_comb begin
        wb_eff   = wb_valid && rd_is_live(wb_rd);
        sel_wb   = rst_n && !wb_hold_q && wb_eff;
        pop      = rst_n && !sel_wb && !q_empty;
        rf_we    = 1'b0;
        rf_rd    = RD_ZERO;
        rf_wdata = '0;
        if (sel_wb) begin
            rf_we    = 1'b1;
            rf_rd    = wb_rd;
            rf_wdata = wb_data;
        end else if (pop) begin
            rf_we    = 1'b1;
            rf_rd    = head_rd;
            rf_wdata = head_data;
        end
    end

    // Scoreboard next state: clear on retire, then set on issue so a same-register set wins.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (ml_issue && rd_is_live(ml_issue_rd)) begin
            busy_d[ml_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Decode hazard: any operand or destination still owned by a multicycle op.
    always_comb begin
        dec_stall = busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd];
    end

    // Starvation timer on the queue head; one-cycle hold once it has waited long enough.
    always_comb begin
        age_d     = age_q;
        wb_hold_d = 1'b0;
        if (q_empty || pop) begin
            age_d = '0;
        end else begin
            if (age_q != AGE_MAX) begin
                age_d = age_q + AW'(1);
            end
            wb_hold_d = !wb_hold_q && (age_q >= AGE_TRIG);
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            age_q     <= '0;
            wb_hold_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            age_q     <= age_d;
            wb_hold_q <= wb_hold_d;
        end
    end

endmodule
